// File: rtl/cache_control_nway_pkg.sv
// ============================================================================
//  Module   : cache_types (package)
//  Purpose  : State encoding and tree pseudo-LRU helpers shared by the
//             N-way cache controller and its PLRU storage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package cache_types;

  // Helpers are written for up to 32 ways (31 tree nodes, 5 tree levels).
  localparam int MAX_WAYS = 32;
  localparam int MAX_LVL  = 5;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WRITE_BACK = 3'd1,
    S_STALL      = 3'd2,
    S_LOAD_LINE  = 3'd3,
    S_UPDATE     = 3'd4
  } cache_state_t;

  typedef logic [MAX_WAYS-2:0] plru_bits_t;
  typedef logic [MAX_WAYS-1:0] way_vec_t;

  // Walk from the root following each node bit (0 = lower half holds victim).
  function automatic int plru_victim(input plru_bits_t bits, input int levels);
    logic [4:0] node;
    logic       b;
    int         way;
    node = '0;
    way  = 0;
    for (int l = 0; l < MAX_LVL; l++) begin
      if (l < levels) begin
        b    = bits[node];
        way  = (way * 2) + int'(b);
        node = {node[3:0], 1'b0} + 5'd1 + {4'd0, b};
      end
    end
    return way;
  endfunction

  // Make every node on the path of 'way' point at the opposite subtree.
  function automatic plru_bits_t plru_touch(input plru_bits_t bits, input int way,
                                            input int levels);
    plru_bits_t r;
    logic [4:0] node;
    logic [4:0] wal;
    logic       d;
    r    = bits;
    node = '0;
    wal  = 5'(way) << (MAX_LVL - levels);
    for (int l = 0; l < MAX_LVL; l++) begin
      if (l < levels) begin
        d       = wal[4];
        wal     = wal << 1;
        r[node] = ~d;
        node    = {node[3:0], 1'b0} + 5'd1 + {4'd0, d};
      end
    end
    return r;
  endfunction

  // Index of the lowest zero bit; callers guarantee one exists.
  function automatic int first_zero(input way_vec_t vec);
    int r;
    r = 0;
    for (int i = MAX_WAYS - 1; i >= 0; i--) begin
      if (!vec[i]) r = i;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_control_nway_plru.sv
// ============================================================================
//  Module   : cache_plru_array
//  Purpose  : Per-set tree pseudo-LRU bits, asynchronous read of the indexed
//             set, synchronous write when the controller touches a way.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_plru_array #(
  parameter int WAYS = 4,
  parameter int SETS = 8,
  parameter int SL   = $clog2(SETS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SL-1:0]   set_idx_i,
  input  logic            we_i,
  input  logic [WAYS-2:0] wdata_i,
  output logic [WAYS-2:0] rdata_o
);

  logic [WAYS-2:0] bits_q [SETS];

  assign rdata_o = bits_q[set_idx_i];

  // Clear every set on reset, otherwise store the touched tree for this set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) bits_q[s] <= '0;
    end else if (we_i) begin
      bits_q[set_idx_i] <= wdata_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_control_nway.sv
// ============================================================================
//  Module   : cache_control_nway
//  Purpose  : Controller for an N-way set-associative write-back,
//             write-allocate cache with in-block PLRU and hit/miss counters.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cache_control_nway
  import cache_types::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 8,
  parameter int CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_i,
  input  logic                     readwrite_i,
  input  logic [$clog2(SETS)-1:0]  set_idx_i,
  input  logic [WAYS-1:0]          hit_i,
  input  logic [WAYS-1:0]          valid_i,
  input  logic [WAYS-1:0]          dirty_i,
  input  logic                     pmem_resp_i,
  input  logic                     clear_counts_i,
  output logic [WAYS-1:0]          data_writeword_o,
  output logic [WAYS-1:0]          data_writeline_o,
  output logic [WAYS-1:0]          tag_write_o,
  output logic [WAYS-1:0]          valid_write_o,
  output logic [WAYS-1:0]          dirty_write_o,
  output logic                     valid_in_o,
  output logic                     dirty_in_o,
  output logic                     pmem_read_o,
  output logic                     pmem_write_o,
  output logic                     cpu_resp_o,
  output logic                     load_adr_o,
  output logic                     wb_adr_sel_o,
  output logic [$clog2(WAYS)-1:0]  victim_way_o,
  output logic [CNT_W-1:0]         hit_count_o,
  output logic [CNT_W-1:0]         miss_count_o
);

  localparam int              WL  = $clog2(WAYS);
  localparam logic [WAYS-1:0] ONE = WAYS'(1);

  cache_state_t     state_q, state_d;
  logic [WL-1:0]    victim_q, victim_d;
  logic             was_miss_q;
  logic [CNT_W-1:0] hit_cnt_q, miss_cnt_q;

  logic [WAYS-2:0]  plru_rd, plru_wr;
  logic             plru_we;
  logic [WL-1:0]    touch_way, hit_way, miss_victim;
  logic             hit_evt, miss_evt;
  way_vec_t         hit_ext, valid_ext;
  plru_bits_t       plru_ext;

  cache_plru_array #(.WAYS(WAYS), .SETS(SETS)) u_plru (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_idx_i (set_idx_i),
    .we_i      (plru_we),
    .wdata_i   (plru_wr),
    .rdata_o   (plru_rd)
  );

  // Way selection: lowest hit, lowest invalid way, or PLRU victim when full.
  always_comb begin
    hit_ext               = '1;
    hit_ext[WAYS-1:0]     = ~hit_i;
    valid_ext             = '1;
    valid_ext[WAYS-1:0]   = valid_i;
    plru_ext              = '0;
    plru_ext[WAYS-2:0]    = plru_rd;
    hit_way               = WL'(first_zero(hit_ext));
    miss_victim           = (&valid_i) ? WL'(plru_victim(plru_ext, WL))
                                       : WL'(first_zero(valid_ext));
    plru_wr               = (WAYS-1)'(plru_touch(plru_ext, int'(touch_way), WL));
  end

  // Next state and the combinational control outputs of each state.
  always_comb begin
    state_d          = state_q;
    victim_d         = victim_q;
    data_writeword_o = '0;
    data_writeline_o = '0;
    tag_write_o      = '0;
    valid_write_o    = '0;
    dirty_write_o    = '0;
    valid_in_o       = 1'b0;
    dirty_in_o       = 1'b0;
    pmem_read_o      = 1'b0;
    pmem_write_o     = 1'b0;
    cpu_resp_o       = 1'b0;
    load_adr_o       = 1'b0;
    wb_adr_sel_o     = 1'b0;
    plru_we          = 1'b0;
    touch_way        = hit_way;
    hit_evt          = 1'b0;
    miss_evt         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_i && (|hit_i)) begin
          cpu_resp_o = 1'b1;
          plru_we    = 1'b1;
          hit_evt    = 1'b1;
          if (readwrite_i) begin
            data_writeword_o = ONE << hit_way;
            dirty_write_o    = ONE << hit_way;
            dirty_in_o       = 1'b1;
          end
        end else if (req_i) begin
          load_adr_o = 1'b1;
          victim_d   = miss_victim;
          if (valid_i[miss_victim] && dirty_i[miss_victim]) begin
            wb_adr_sel_o = 1'b1;
            state_d      = S_WRITE_BACK;
          end else begin
            state_d = S_LOAD_LINE;
          end
        end
      end
      S_WRITE_BACK: begin
        pmem_write_o = 1'b1;
        if (pmem_resp_i) state_d = S_STALL;
      end
      S_STALL: begin
        load_adr_o = 1'b1;
        state_d    = S_LOAD_LINE;
      end
      S_LOAD_LINE: begin
        pmem_read_o = 1'b1;
        if (pmem_resp_i) begin
          data_writeline_o = ONE << victim_q;
          tag_write_o      = ONE << victim_q;
          valid_write_o    = ONE << victim_q;
          dirty_write_o    = ONE << victim_q;
          valid_in_o       = 1'b1;
          plru_we          = 1'b1;
          touch_way        = victim_q;
          state_d          = S_UPDATE;
        end
      end
      S_UPDATE: begin
        miss_evt = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched victim, miss marker and saturating counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      victim_q   <= '0;
      was_miss_q <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      if (hit_evt)       was_miss_q <= 1'b0;
      else if (miss_evt) was_miss_q <= 1'b1;
      if (clear_counts_i) begin
        hit_cnt_q  <= '0;
        miss_cnt_q <= '0;
      end else begin
        if (hit_evt && !was_miss_q && (hit_cnt_q != '1))
          hit_cnt_q <= hit_cnt_q + CNT_W'(1);
        if (miss_evt && (miss_cnt_q != '1))
          miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      end
    end
  end

  assign victim_way_o = victim_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cache_control_nway.sv
// ============================================================================
//  Module   : tb_cache_control_nway
//  Purpose  : Bench acting as the cache datapath and memory for the N-way
//             controller, checked against a behavioural cache model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_cache_control_nway;

  localparam int WAYS  = 4;
  localparam int SETS  = 8;
  localparam int CNT_W = 4;
  localparam int L     = $clog2(WAYS);
  localparam int SL    = $clog2(SETS);
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            req_i = 1'b0, readwrite_i = 1'b0, pmem_resp_i = 1'b0, clear_counts_i = 1'b0;
  logic [SL-1:0]   set_idx_i = '0;
  logic [WAYS-1:0] hit_i = '0, valid_i = '0, dirty_i = '0;
  logic [WAYS-1:0] data_writeword_o, data_writeline_o, tag_write_o, valid_write_o, dirty_write_o;
  logic            valid_in_o, dirty_in_o, pmem_read_o, pmem_write_o, cpu_resp_o, load_adr_o, wb_adr_sel_o;
  logic [L-1:0]    victim_way_o;
  logic [CNT_W-1:0] hit_count_o, miss_count_o;

  cache_control_nway #(.WAYS(WAYS), .SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .readwrite_i(readwrite_i), .set_idx_i(set_idx_i),
    .hit_i(hit_i), .valid_i(valid_i), .dirty_i(dirty_i), .pmem_resp_i(pmem_resp_i),
    .clear_counts_i(clear_counts_i), .data_writeword_o(data_writeword_o),
    .data_writeline_o(data_writeline_o), .tag_write_o(tag_write_o), .valid_write_o(valid_write_o),
    .dirty_write_o(dirty_write_o), .valid_in_o(valid_in_o), .dirty_in_o(dirty_in_o),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o), .cpu_resp_o(cpu_resp_o),
    .load_adr_o(load_adr_o), .wb_adr_sel_o(wb_adr_sel_o), .victim_way_o(victim_way_o),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural cache: tags/valid/dirty per way, PLRU tree bits per set.
  int m_tag   [SETS][WAYS];
  bit m_valid [SETS][WAYS];
  bit m_dirty [SETS][WAYS];
  bit m_plru  [SETS][WAYS-1];
  int m_hits = 0, m_miss = 0;
  bit m_was_miss = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  function automatic int m_hit(input int s, input int tg);
    for (int w = 0; w < WAYS; w++) if (m_valid[s][w] && m_tag[s][w] == tg) return w;
    return -1;
  endfunction

  // Node on level l of way w's path is (2^l - 1) + (w >> (L-l)); the way's
  // direction there is bit (L-1-l) of w. A way is the victim when every
  // node on its path points toward it.
  function automatic int m_victim(input int s);
    bit ok;
    for (int w = 0; w < WAYS; w++) if (!m_valid[s][w]) return w;
    for (int w = 0; w < WAYS; w++) begin
      ok = 1'b1;
      for (int l = 0; l < L; l++)
        if (int'(m_plru[s][(1 << l) - 1 + (w >> (L - l))]) != ((w >> (L - 1 - l)) & 1)) ok = 1'b0;
      if (ok) return w;
    end
    return 0;
  endfunction

  task automatic m_touch(input int s, input int w);
    for (int l = 0; l < L; l++)
      m_plru[s][(1 << l) - 1 + (w >> (L - l))] = (((w >> (L - 1 - l)) & 1) == 0);
  endtask

  task automatic drive_dp(input int s, input int tg);
    for (int w = 0; w < WAYS; w++) begin
      hit_i[w]   = m_valid[s][w] && (m_tag[s][w] == tg);
      valid_i[w] = m_valid[s][w];
      dirty_i[w] = m_valid[s][w] ? m_dirty[s][w] : 1'($urandom % 2);
    end
  endtask

  // Caller positions this at a negedge; ends one cycle later with reset released.
  task automatic do_reset();
    rst_n = 1'b0; req_i = 1'b0; pmem_resp_i = 1'b0; clear_counts_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_resp",   32'(cpu_resp_o), 0);
    chk("rst_pmem",   32'({pmem_read_o, pmem_write_o, load_adr_o, wb_adr_sel_o}), 0);
    chk("rst_writes", 32'({data_writeword_o, data_writeline_o, tag_write_o, valid_write_o, dirty_write_o}), 0);
    chk("rst_vin",    32'({valid_in_o, dirty_in_o}), 0);
    chk("rst_victim", 32'(victim_way_o), 0);
    chk("rst_hits",   32'(hit_count_o), 0);
    chk("rst_miss",   32'(miss_count_o), 0);
    for (int s = 0; s < SETS; s++) for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
    m_hits = 0; m_miss = 0; m_was_miss = 1'b0;
  endtask

  task automatic hit_cycle(input int s, input int tg, input bit rw, input bit clr);
    int h;
    @(negedge clk);
    req_i = 1'b1; set_idx_i = SL'(s); readwrite_i = rw; clear_counts_i = clr; pmem_resp_i = 1'b0;
    drive_dp(s, tg);
    #1;
    h = m_hit(s, tg);
    chk("hit_resp",  32'(cpu_resp_o), 1);
    chk("hit_wword", 32'(data_writeword_o), rw ? (1 << h) : 0);
    chk("hit_dwr",   32'(dirty_write_o), rw ? (1 << h) : 0);
    chk("hit_din",   32'(dirty_in_o), 32'(rw));
    chk("hit_other", 32'({data_writeline_o, tag_write_o, valid_write_o, load_adr_o, pmem_read_o, pmem_write_o}), 0);
    m_touch(s, h);
    if (rw) m_dirty[s][h] = 1'b1;
    if (clr) begin m_hits = 0; m_miss = 0; end
    else if (!m_was_miss) m_hits = sat(m_hits);
    m_was_miss = 1'b0;
    @(posedge clk);
  endtask

  task automatic miss_seq(input int s, input int tg, input bit rw, input int wb_lat, input bit abort);
    int v, lat;
    bit wb;
    v  = m_victim(s);
    wb = m_valid[s][v] && m_dirty[s][v];
    @(negedge clk);
    req_i = 1'b1; set_idx_i = SL'(s); readwrite_i = rw; clear_counts_i = 1'b0;
    pmem_resp_i = 1'($urandom % 2);
    drive_dp(s, tg);
    #1;
    chk("miss_resp", 32'(cpu_resp_o), 0);
    chk("miss_ld",   32'(load_adr_o), 1);
    chk("miss_sel",  32'(wb_adr_sel_o), 32'(wb));
    chk("miss_pmem", 32'({pmem_read_o, pmem_write_o}), 0);
    @(posedge clk);
    if (wb) begin
      lat = (wb_lat > 0) ? wb_lat : int'($urandom_range(1, 5));
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        req_i = 1'($urandom % 2); pmem_resp_i = (i == lat - 1);
        #1;
        chk("wb_write",  32'({pmem_write_o, pmem_read_o, cpu_resp_o}), 32'b100);
        chk("wb_victim", 32'(victim_way_o), 32'(v));
        @(posedge clk);
      end
      @(negedge clk);
      pmem_resp_i = 1'($urandom % 2);
      #1;
      chk("stall_ld",   32'({load_adr_o, wb_adr_sel_o}), 32'b10);
      chk("stall_pmem", 32'({pmem_read_o, pmem_write_o}), 0);
      @(posedge clk);
    end
    lat = int'($urandom_range(1, 4));
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      req_i = 1'($urandom % 2);
      pmem_resp_i = abort ? 1'b0 : (i == lat - 1);
      #1;
      chk("ld_read",   32'({pmem_read_o, pmem_write_o, cpu_resp_o}), 32'b100);
      chk("ld_victim", 32'(victim_way_o), 32'(v));
      if (abort) begin
        do_reset();
        return;
      end
      if (i == lat - 1) begin
        chk("ld_wline", 32'(data_writeline_o), 1 << v);
        chk("ld_tagw",  32'(tag_write_o), 1 << v);
        chk("ld_valw",  32'(valid_write_o), 1 << v);
        chk("ld_dirw",  32'(dirty_write_o), 1 << v);
        chk("ld_vin",   32'({valid_in_o, dirty_in_o}), 32'b10);
      end else begin
        chk("ld_wait",  32'({data_writeline_o, tag_write_o}), 0);
      end
      @(posedge clk);
    end
    m_tag[s][v] = tg; m_valid[s][v] = 1'b1; m_dirty[s][v] = 1'b0;
    m_touch(s, v);
    @(negedge clk);
    req_i = 1'($urandom % 2); pmem_resp_i = 1'($urandom % 2);
    drive_dp(s, tg);
    #1;
    chk("upd_quiet", 32'({cpu_resp_o, pmem_read_o, pmem_write_o, load_adr_o}), 0);
    chk("upd_wr",    32'({data_writeword_o, data_writeline_o, tag_write_o}), 0);
    @(posedge clk);
    m_miss = sat(m_miss); m_was_miss = 1'b1;
    hit_cycle(s, tg, rw, 1'b0);
  endtask

  task automatic do_access(input int s, input int tg, input bit rw, input int wb_lat,
                           input bit abort, input bit rnd_clr);
    if (m_hit(s, tg) >= 0) hit_cycle(s, tg, rw, rnd_clr && (($urandom % 16) == 0));
    else begin
      miss_seq(s, tg, rw, wb_lat, abort);
      if (abort) return;
    end
    @(negedge clk);
    req_i = 1'b0; clear_counts_i = 1'b0; pmem_resp_i = 1'b0;
    #1;
    chk("idle_resp", 32'(cpu_resp_o), 0);
    chk("hit_count", 32'(hit_count_o), 32'(m_hits));
    chk("miss_count", 32'(miss_count_o), 32'(m_miss));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_tag[s][w] = 0; m_valid[s][w] = 1'b0; m_dirty[s][w] = 1'b0;
      end
    @(negedge clk);
    do_reset();
    // Cold fills of set 3, way 2 left dirty, then a write hit on way 1.
    do_access(3, 1, 1'b0, 0, 1'b0, 1'b0);
    do_access(3, 2, 1'b0, 0, 1'b0, 1'b0);
    do_access(3, 3, 1'b1, 0, 1'b0, 1'b0);
    do_access(3, 4, 1'b0, 0, 1'b0, 1'b0);
    do_access(3, 2, 1'b1, 0, 1'b0, 1'b0);
    // Fresh PLRU on a full set: clean way 0, then dirty way 2 with 5-cycle writeback.
    @(negedge clk);
    do_reset();
    do_access(3, 9,  1'b0, 0, 1'b0, 1'b0);
    do_access(3, 10, 1'b0, 5, 1'b0, 1'b0);
    // Hit counter saturation and clear-over-increment priority.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 17; i++) do_access(3, 4, 1'b0, 0, 1'b0, 1'b0);
    chk("hit_sat", 32'(hit_count_o), CMAX);
    hit_cycle(3, 4, 1'b0, 1'b1);
    @(negedge clk);
    req_i = 1'b0; clear_counts_i = 1'b0;
    #1;
    chk("hit_clr", 32'(hit_count_o), 0);
    // Reset while filling a cold set.
    do_access(5, 7, 1'b0, 0, 1'b1, 1'b0);
    // Random traffic.
    for (int i = 0; i < 200; i++)
      do_access(int'($urandom_range(0, SETS - 1)), int'($urandom_range(0, 6)),
                1'($urandom % 2), 0, 1'b0, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
